// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// State encoding, port index type and address-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  typedef logic port_idx_t;

  localparam int TO_MIN = 2;

  function automatic int calc_aw(input int r, input int c);
    return $clog2(r * c);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins,
// a tie goes to the port that was not served last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  port_idx_t lp,
  output logic      gnt_vld,
  output port_idx_t gnt_idx
);

  // winner selection
  always_comb begin
    gnt_vld = req0 | req1;
    gnt_idx = (req0 && req1) ? ~lp : req1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer of two single-word ports onto one master.
// Optional read timeout: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int R      = 4,
  parameter int C      = 4,
  parameter int N      = 4,
  parameter int TO_CYC = 16,
  localparam int AW    = calc_aw(R, C)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [N-1:0]  wdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [N-1:0]  wdata1,
  output logic          ready0,
  output logic [N-1:0]  rdata0,
  output logic          err0,
  output logic          ready1,
  output logic [N-1:0]  rdata1,
  output logic          err1,
  output logic          m_cs,
  output logic          m_req,
  output logic          m_rw,
  output logic [AW-1:0] m_addr,
  output logic [N-1:0]  m_wdata,
  input  logic          m_valid,
  input  logic [N-1:0]  m_rdata
);

  if (TO_CYC < TO_MIN) begin : g_bad_to
    $error("TO_CYC must be >= 2");
  end

  state_e          state_q, state_d;
  port_idx_t       lp_q, lp_d;
  port_idx_t       win_q, win_d;
  logic            m_cs_q, m_cs_d;
  logic            m_req_q, m_req_d;
  logic            m_rw_q, m_rw_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [N-1:0]    m_wdata_q, m_wdata_d;
  logic            rdy0_q, rdy0_d;
  logic            rdy1_q, rdy1_d;
  logic [N-1:0]    rd0_q, rd0_d;
  logic [N-1:0]    rd1_q, rd1_d;
  logic            er0_q, er0_d;
  logic            er1_q, er1_d;

  logic            gnt_vld;
  port_idx_t       gnt_idx;
  logic            tmo;
  logic            fin;
  logic            fin_err;
  logic [N-1:0]    fin_data;

  rr_pick2 u_pick (
    .req0    (req0),
    .req1    (req1),
    .lp      (lp_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // count WAIT cycles without valid; zero outside WAIT
  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT && !m_valid)
      cnt_d = cnt_q + 1'b1;
  end

  // timeout counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tmo = (cnt_q == CW'(TO_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // next state, command latch and registered outputs
  always_comb begin
    state_d   = state_q;
    lp_d      = lp_q;
    win_d     = win_q;
    m_cs_d    = 1'b0;
    m_req_d   = 1'b0;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          win_d     = gnt_idx;
          m_rw_d    = gnt_idx ? rw1 : rw0;
          m_addr_d  = gnt_idx ? addr1 : addr0;
          m_wdata_d = gnt_idx ? wdata1 : wdata0;
          m_cs_d    = 1'b1;
          m_req_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (m_rw_q) begin
          m_cs_d  = 1'b1;
          state_d = WAIT;
        end else begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        if (m_valid) begin
          fin      = 1'b1;
          fin_data = m_rdata;
          state_d  = DONE;
        end else if (tmo) begin
          fin      = 1'b1;
          fin_err  = 1'b1;
          state_d  = DONE;
        end else begin
          m_cs_d   = 1'b1;
        end
      end
      DONE: begin
        lp_d    = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy0_d = fin && !win_q;
    rdy1_d = fin && win_q;
    rd0_d  = rdy0_d ? fin_data : '0;
    rd1_d  = rdy1_d ? fin_data : '0;
    er0_d  = rdy0_d && fin_err;
    er1_d  = rdy1_d && fin_err;
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lp_q      <= 1'b1;
      win_q     <= 1'b0;
      m_cs_q    <= 1'b0;
      m_req_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      er0_q     <= 1'b0;
      er1_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lp_q      <= lp_d;
      win_q     <= win_d;
      m_cs_q    <= m_cs_d;
      m_req_q   <= m_req_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdy0_q    <= rdy0_d;
      rdy1_q    <= rdy1_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
      er0_q     <= er0_d;
      er1_q     <= er1_d;
    end
  end

  assign ready0  = rdy0_q;
  assign ready1  = rdy1_q;
  assign rdata0  = rd0_q;
  assign rdata1  = rd1_q;
  assign err0    = er0_q;
  assign err1    = er1_q;
  assign m_cs    = m_cs_q;
  assign m_req   = m_req_q;
  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Timeout cases run when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 0, rw0 = 0, req1 = 0, rw1 = 0;
  logic [3:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic       ready0, ready1, err0, err1;
  logic [3:0] rdata0, rdata1;
  logic       m_cs, m_req, m_rw;
  logic [3:0] m_addr, m_wdata;
  logic       m_valid;
  logic [3:0] m_rdata;

  mem_port_arbiter #(.R(4), .C(4), .N(4), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
    .ready0(ready0), .rdata0(rdata0), .err0(err0),
    .ready1(ready1), .rdata1(rdata1), .err1(err1),
    .m_cs(m_cs), .m_req(m_req), .m_rw(m_rw),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_valid(m_valid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [3:0] a;
    logic [3:0] d;
  } iss_t;

  typedef struct packed {
    logic       p;
    logic [3:0] d;
    logic       e;
  } rsp_t;

  iss_t iq[$];
  rsp_t rq[$];
  iss_t ie;
  rsp_t re;
  int   checks = 0;
  int   failures = 0;

  int         rsp_dly = 0;
  int         rsp_cnt = 0;
  logic [3:0] rsp_val = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  // datapath model: valid rsp_dly WAIT cycles after an issued read
  initial begin
    m_valid = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      m_valid = 1'b0;
      m_rdata = '0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          m_valid = 1'b1;
          m_rdata = rsp_val;
        end
      end
      if (m_req && m_rw && rsp_dly > 0)
        rsp_cnt = rsp_dly;
    end
  end

  // monitor: compare issues and completions against the queues
  always @(negedge clk) begin
    if (m_req) begin
      if (iq.size() == 0) fail("unexpected_issue");
      else begin
        ie = iq.pop_front();
        chk("issue", {m_cs, m_rw, m_addr, m_wdata},
            {1'b1, ie.rw, ie.a, ie.d});
      end
    end
    if (ready0 || ready1) begin
      if (rq.size() == 0) fail("unexpected_ready");
      else begin
        re = rq.pop_front();
        chk("response",
            {ready1, ready0, ready1 ? rdata1 : rdata0, err0 | err1},
            {re.p, ~re.p, re.d, re.e});
      end
    end
  end

  task automatic xact(input bit p, input bit rw, input logic [3:0] a,
                      input logic [3:0] d, output int cyc);
    @(negedge clk);
    if (!p) begin
      req0 = 1; rw0 = rw; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1; rw1 = rw; addr1 = a; wdata1 = d;
    end
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(p ? ready1 : ready0) && cyc < 200);
    if (cyc >= 200) fail("xact_timeout");
    if (!p) req0 = 0;
    else    req1 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [22:0] outs();
    return {ready0, ready1, rdata0, rdata1, err0, err1,
            m_cs, m_req, m_rw, m_addr, m_wdata};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  int cyc, c2, bad;

  initial begin
    idle(2);
    chk("reset_outputs", outs(), 0);
    rst = 0;
    idle(1);

    iq.push_back('{1'b1, 4'h3, 4'h0});
    rsp_dly = 0;
    @(negedge clk);
    req0 = 1; rw0 = 1; addr0 = 4'h3; wdata0 = 0;
    @(negedge clk);
    req0 = 0;
    idle(2);
    chk("in_wait", {m_cs, m_req}, 2'b10);
    rst = 1;
    #1;
    chk("reset_mid_wait", outs(), 0);
    @(negedge clk);
    rst = 0;
    idle(1);

    iq.push_back('{1'b0, 4'h1, 4'h3});
    iq.push_back('{1'b0, 4'h2, 4'h4});
    rq.push_back('{1'b0, 4'h0, 1'b0});
    rq.push_back('{1'b1, 4'h0, 1'b0});
    fork
      xact(0, 0, 4'h1, 4'h3, cyc);
      xact(1, 0, 4'h2, 4'h4, c2);
    join
    idle(2);

    iq.push_back('{1'b0, 4'h9, 4'hA});
    rq.push_back('{1'b1, 4'h0, 1'b0});
    xact(1, 0, 4'h9, 4'hA, cyc);
    chk("write_latency", cyc, 2);
    idle(2);

    for (int i = 0; i < 3; i++) begin
      iq.push_back('{1'b0, 4'(2 * i), 4'(1 + i)});
      iq.push_back('{1'b0, 4'(2 * i + 1), 4'(8 + i)});
      rq.push_back('{1'b0, 4'h0, 1'b0});
      rq.push_back('{1'b1, 4'h0, 1'b0});
    end
    fork
      begin
        for (int i = 0; i < 3; i++)
          xact(0, 0, 4'(2 * i), 4'(1 + i), cyc);
      end
      begin
        for (int j = 0; j < 3; j++)
          xact(1, 0, 4'(2 * j + 1), 4'(8 + j), c2);
      end
    join
    idle(2);

    rsp_dly = 3;
    rsp_val = 4'h6;
    iq.push_back('{1'b1, 4'h5, 4'h0});
    rq.push_back('{1'b0, 4'h6, 1'b0});
    xact(0, 1, 4'h5, 4'h0, cyc);
    chk("read_latency", cyc, 5);
    idle(2);

    rsp_val = 4'hC;
    iq.push_back('{1'b1, 4'h7, 4'h0});
    rq.push_back('{1'b0, 4'hC, 1'b0});
    @(negedge clk);
    req0 = 1; rw0 = 1; addr0 = 4'h7; wdata0 = 0;
    @(negedge clk);
    req1 = 1; rw1 = 0; addr1 = 4'hE; wdata1 = 4'hF;
    @(negedge clk);
    req1 = 0;
    req0 = 0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!ready0 && cyc < 50);
    chk("dropped_req_ready", ready0, 1);
    idle(6);

`ifdef MEM_ARB_TIMEOUT_EN
    rsp_dly = 0;
    iq.push_back('{1'b1, 4'h2, 4'h0});
    rq.push_back('{1'b0, 4'h0, 1'b1});
    xact(0, 1, 4'h2, 4'h0, cyc);
    chk("timeout_latency", cyc, 18);
    idle(2);

    rsp_dly = 16;
    rsp_val = 4'h9;
    iq.push_back('{1'b1, 4'h4, 4'h0});
    rq.push_back('{1'b1, 4'h9, 1'b0});
    xact(1, 1, 4'h4, 4'h0, cyc);
    chk("valid_at_limit_latency", cyc, 18);
    idle(2);
`else
    rsp_dly = 0;
    iq.push_back('{1'b1, 4'h2, 4'h0});
    @(negedge clk);
    req0 = 1; rw0 = 1; addr0 = 4'h2; wdata0 = 0;
    @(negedge clk);
    req0 = 0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(m_cs && !m_req && !err0 && !err1 && !ready0)) bad++;
    end
    chk("wait_holds", bad, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle(2);
`endif

    idle(4);
    chk("issue_queue_empty", iq.size(), 0);
    chk("resp_queue_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
